// File: rtl/input_conditioner.sv
// Button/switch conditioner: two-flop synchronizer, counter debouncer,
// debounced level, one-cycle rise strobe and a stretched press pulse.
module input_conditioner #(
   parameter int STABLE_CYCLES = 16,
   parameter int PULSE_CYCLES  = 2
) (
   input  logic CLK,
   input  logic reset,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_rise,
   output logic btn_pulse
);

   localparam int CW = $clog2(STABLE_CYCLES) + 1;
   localparam int PW = $clog2(PULSE_CYCLES) + 1;

   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [PW-1:0] PCNT_ONE = PW'(1);
   localparam logic [PW-1:0] PLOAD    = PW'(PULSE_CYCLES);

   typedef enum logic [1:0] {
      STABLE_LO,
      WAIT_HI,
      STABLE_HI,
      WAIT_LO
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic            s1;
   logic            s2;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_nx;
   logic [PW-1:0]   pcnt;
   logic [PW-1:0]   pcnt_nx;
   logic            level_nx;
   logic            rise_nx;

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= btn_raw;
         s2 <= s1;
      end
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state     <= STABLE_LO;
         cnt       <= '0;
         pcnt      <= '0;
         btn_level <= 1'b0;
         btn_rise  <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         pcnt      <= pcnt_nx;
         btn_level <= level_nx;
         btn_rise  <= rise_nx;
      end
   end

   // The pulse runs down on its own; only an accepted rise reloads it.
   always_comb begin
      state_nx = state;
      cnt_nx   = '0;
      level_nx = btn_level;
      rise_nx  = 1'b0;
      pcnt_nx  = (pcnt != '0) ? pcnt - PCNT_ONE : '0;
      unique case (state)
         STABLE_LO: begin
            if (s2) begin
               state_nx = WAIT_HI;
               cnt_nx   = CNT_ONE;
            end
         end
         WAIT_HI: begin
            if (!s2) begin
               state_nx = STABLE_LO;
            end else if (cnt == CNT_LAST) begin
               state_nx = STABLE_HI;
               level_nx = 1'b1;
               rise_nx  = 1'b1;
               pcnt_nx  = PLOAD;
            end else begin
               cnt_nx = cnt + CNT_ONE;
            end
         end
         STABLE_HI: begin
            if (!s2) begin
               state_nx = WAIT_LO;
               cnt_nx   = CNT_ONE;
            end
         end
         WAIT_LO: begin
            if (s2) begin
               state_nx = STABLE_HI;
            end else if (cnt == CNT_LAST) begin
               state_nx = STABLE_LO;
               level_nx = 1'b0;
            end else begin
               cnt_nx = cnt + CNT_ONE;
            end
         end
      endcase
   end

   assign btn_pulse = (pcnt != '0);

endmodule
